pwm_bank: RTL
=============

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent PWM outputs (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: width of counter, period and duty values.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1: counter run enable.
REQ-007 SHALL have port mode, input, 1: alignment select, 0 = edge-aligned, 1 = center-aligned.
REQ-008 SHALL have port period, input, CNT_W: period value P.
REQ-009 SHALL have port wr_en, input, 1: duty write strobe.
REQ-010 SHALL have port wr_ch, input, max(1,$clog2(CHANNELS)): target channel of a duty write.
REQ-011 SHALL have port wr_duty, input, CNT_W: duty value D for the write.
REQ-012 SHALL have port pwm_out, output, CHANNELS: PWM outputs.
REQ-013 SHALL have port period_end, output, 1: one-cycle pulse marking the last cycle of each PWM period.

Function
REQ-014 SHALL keep one shadow duty register and one active duty register per channel, plus an active period and an active mode.
REQ-015 SHALL, on wr_en=1 with wr_ch < CHANNELS, load wr_duty into that channel's shadow register only; an out-of-range wr_ch is ignored; a later write to the same channel overwrites the earlier one.
REQ-016 SHALL copy all shadow duties, period and mode into the active registers in the boundary cycle (the cycle whose next counter value is 0); a write in that same cycle reaches the shadow register but is committed at the following boundary.
REQ-017 SHALL, in edge mode, count 0,1..P and then wrap to 0 (period length P+1 cycles); the boundary is cnt == P.
REQ-018 SHALL, in center mode, count up 0..P, then down P-1..1, then return to 0 (period length 2P cycles); the boundary is down-count at cnt == 1, or up-count at cnt == P when P <= 1.
REQ-019 SHALL, for P = 0 in either mode, hold cnt at 0 and treat every cycle as a boundary.
REQ-020 SHALL register pwm_out[i] as en & (cnt < active_duty[i]), so pwm_out lags the counter by one cycle.
REQ-021 SHALL compare unsigned: D = 0 gives a constant low output; D > max count (edge: D >= P+1; center: D > P) gives a constant high output.
REQ-022 SHALL register period_end high for exactly one cycle, in the cycle after each boundary cycle, only while en = 1; it is aligned with pwm_out.
REQ-023 SHALL, while en = 0: hold cnt at 0 and the direction at up; force pwm_out and period_end low; keep accepting writes; copy shadow to active on every cycle.
REQ-024 SHALL start a new period from cnt = 0 on the first en = 1 cycle, using the values last committed.
REQ-025 SHALL take mode or period changes at the boundary only; no mid-period glitch or truncation occurs.

Reset
REQ-026 SHALL, on rst = 1 (asynchronous), clear cnt to 0, set the direction to up, clear all shadow and active duties, clear active period to 0 and active mode to 0, and clear pwm_out and period_end to 0.
REQ-027 SHALL resume with the REQ-023/024 behaviour on the first clk edge after rst deasserts; a write coincident with reset release is taken.

Verification
REQ-028 SHALL verify edge-mode duty ratios: en=0, write ch0..3 = 20/40/60/80, P = 99, mode 0, then en = 1 -> per 100-cycle period, high counts are 20/40/60/80 and period_end pulses every 100 cycles.
REQ-029 SHALL verify double buffering: mid-period, write ch0 = 50 -> ch0 keeps 20 high cycles until period_end, then 50 high cycles in the next period.
REQ-030 SHALL verify center mode: P = 4, D = 2 -> cnt sequence 0,1,2,3,4,3,2,1 repeats; period 8 cycles; pwm_out high 3 cycles per period (cnt 0,1,1).
REQ-031 SHALL verify the duty extremes: D = 0 -> constant low; D = 255 with P = 99 -> constant high; P = 0 with D = 1 -> constant high and period_end every cycle.
REQ-032 SHALL verify reset mid-period: rst pulse at cnt = 37 -> outputs go 0 immediately; after release, all duties read as 0 (pwm_out stays low) until new writes and a boundary occur.
REQ-033 SHALL verify boundary-cycle writes: a write in the boundary cycle is not applied in the next period but is applied in the one after; a mode 0->1 change mid-period takes effect only after period_end.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: bank of PWM channels sharing one counter.
//
// Each channel has a shadow duty (written through wr_*) and an active duty
// used for comparison. Shadow duties, period and mode are committed to the
// active set at the period boundary (the cycle whose next count is 0), and
// on every cycle while en is low. This keeps period and mode changes
// glitch-free.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         counter run enable; low holds cnt at 0 and outputs low
//   mode       0 = edge-aligned (0..P), 1 = center-aligned (0..P..1)
//   period     period value P
//   wr_en      duty write strobe
//   wr_ch      channel index of the duty write (out-of-range ignored)
//   wr_duty    duty value D
//   pwm_out    registered outputs, en & (cnt < active_duty)
//   period_end one-cycle pulse aligned with pwm_out for the boundary cycle
//
// State table (counter sequencer):
//   r_down | meaning
//   0      | counting up (always in edge mode)
//   1      | counting down (center mode, between P and 1)

module pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [CNT_W-1:0]    period,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end
);

  logic [CNT_W-1:0]    r_shadow [CHANNELS];
  logic [CNT_W-1:0]    r_active [CHANNELS];
  logic [CNT_W-1:0]    r_period;
  logic                r_mode;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_down;
  logic [CHANNELS-1:0] r_pwm;
  logic                r_pend;
  logic                w_boundary;
  logic                w_commit;

  // Boundary = last cycle of the period. In center mode with P <= 1 there
  // is no down-count phase, so the turnaround point P ends the period.
  always_comb begin
    w_boundary = 1'b0;
    if (!r_mode)
      w_boundary = (r_cnt == r_period);
    else if (r_period <= CNT_W'(1))
      w_boundary = !r_down && (r_cnt == r_period);
    else
      w_boundary = r_down && (r_cnt == CNT_W'(1));
  end

  assign w_commit = !en || w_boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_period <= '0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_down   <= 1'b0;
      r_pwm    <= '0;
      r_pend   <= 1'b0;
    end else begin
      // Commit uses the pre-edge shadow, so a write in the boundary cycle
      // lands in the shadow and waits for the next boundary.
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_commit)
          r_active[i] <= r_shadow[i];
        if (wr_en && (wr_ch == CH_W'(i)))
          r_shadow[i] <= wr_duty;
        r_pwm[i] <= en && (r_cnt < r_active[i]);
      end
      if (w_commit) begin
        r_period <= period;
        r_mode   <= mode;
      end
      r_pend <= en && w_boundary;

      if (w_commit) begin
        r_cnt  <= '0;
        r_down <= 1'b0;
      end else if (!r_mode) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!r_down) begin
        if (r_cnt == r_period) begin
          r_cnt  <= r_cnt - CNT_W'(1);
          r_down <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign pwm_out    = r_pwm;
  assign period_end = r_pend;

endmodule
